arbiter_rr4_hold: RTL and testbench

Round-robin arbiter that shares one resource between four requesters. It issues a one-hot grant, and the grant is held until the owner releases its request or a maximum hold time expires. It sits between the requester FSMs and the shared resource, and replaces the fixed-priority 3-input arbitration with a fair, bounded-latency scheme. Grants and all status outputs are registered. The block inserts one turnaround cycle between owners.

---
 rtl/arbiter_rr4_hold_if.sv | 12 +
 rtl/arbiter_rr4_hold.sv | 101 ++++++++++
 tb/tb_arbiter_rr4_hold.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arbiter_rr4_hold_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// master = requester side (drives req), slave = arbiter side (drives status).
interface arbiter_rr4_hold_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;

    modport master (output req, input grant, owner, busy, timeout);
    modport slave  (input req, output grant, owner, busy, timeout);
endinterface

// File: rtl/arbiter_rr4_hold.sv
// Four-way round-robin arbiter with grant hold bounded by MAX_HOLD cycles.
// Grant follows sampled req by one edge; one all-zero turnaround cycle separates owners.
module arbiter_rr4_hold #(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    arbiter_rr4_hold_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [7:0] MAX_HOLD_C = MAX_HOLD[7:0];

    state_t      state_q;
    logic [1:0]  ptr_q;
    logic [1:0]  owner_q;
    logic [7:0]  cnt_q;
    logic [3:0]  grant_q;
    logic        busy_q;
    logic        timeout_q;

    logic        req_any;
    logic [1:0]  win_idx;

    // Cyclic scan starting at p; first set bit wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic       found;
        rr_pick = p;
        found   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = p + 2'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    always_comb begin
        req_any = |bus.req;
        win_idx = rr_pick(bus.req, ptr_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            owner_q   <= 2'd0;
            cnt_q     <= 8'd0;
            grant_q   <= 4'd0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, RELEASE: begin
                    // ptr_q already points past the previous owner when leaving RELEASE.
                    timeout_q <= 1'b0;
                    if (req_any) begin
                        state_q <= GRANT;
                        grant_q <= 4'b0001 << win_idx;
                        owner_q <= win_idx;
                        cnt_q   <= 8'd1;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                GRANT: begin
                    if (!bus.req[owner_q] || cnt_q == MAX_HOLD_C) begin
                        // A voluntary drop takes precedence, so timeout only on a held request.
                        state_q   <= RELEASE;
                        grant_q   <= 4'd0;
                        busy_q    <= 1'b0;
                        timeout_q <= bus.req[owner_q];
                        ptr_q     <= owner_q + 2'd1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    grant_q   <= 4'd0;
                    busy_q    <= 1'b0;
                    timeout_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant   = grant_q;
    assign bus.owner   = owner_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_arbiter_rr4_hold.sv
// Bench for arbiter_rr4_hold: MAX_HOLD=8 and MAX_HOLD=1 instances against a
// behavioural owner/turn model, directed scenarios plus randomized request traffic.
module tb_arbiter_rr4_hold;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    arbiter_rr4_hold_if bus8();
    arbiter_rr4_hold_if bus1();

    arbiter_rr4_hold #(.MAX_HOLD(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    arbiter_rr4_hold #(.MAX_HOLD(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: who owns the resource (-1 = nobody), how long, whose turn is next.
    int m_own  [2];
    int m_held [2];
    int m_next [2];
    int m_last [2];
    bit m_to   [2];

    function automatic void model_reset(input int id);
        m_own[id]  = -1;
        m_held[id] = 0;
        m_next[id] = 0;
        m_last[id] = 0;
        m_to[id]   = 1'b0;
    endfunction

    function automatic void model_step(input int id, input logic [3:0] r, input int maxh);
        int c;
        m_to[id] = 1'b0;
        if (m_own[id] >= 0) begin
            if (!r[m_own[id]] || m_held[id] == maxh) begin
                m_to[id]   = r[m_own[id]];
                m_next[id] = (m_own[id] + 1) % 4;
                m_own[id]  = -1;
            end else begin
                m_held[id] = m_held[id] + 1;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                c = (m_next[id] + k) % 4;
                if (r[c] && m_own[id] < 0) begin
                    m_own[id]  = c;
                    m_last[id] = c;
                    m_held[id] = 1;
                end
            end
        end
    endfunction

    // Expected {grant, owner, busy, timeout}
    function automatic logic [7:0] exp_vec(input int id);
        logic [3:0] g;
        logic [1:0] o;
        g = (m_own[id] >= 0) ? (4'b0001 << m_own[id]) : 4'b0000;
        o = 2'(m_last[id]);
        return {g, o, (m_own[id] >= 0), m_to[id]};
    endfunction

    task automatic drive(input logic [3:0] r8, input logic [3:0] r1);
        bus8.req = r8;
        bus1.req = r1;
        @(posedge clk);
        model_step(0, r8, 8);
        model_step(1, r1, 1);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        bus8.req = 4'b1111;
        bus1.req = 4'b1111;
        model_reset(0);
        model_reset(1);
        repeat (2) @(negedge clk);
        checks++;
        if ({bus8.grant, bus8.owner, bus8.busy, bus8.timeout} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got %b want %b",
                     {bus8.grant, bus8.owner, bus8.busy, bus8.timeout}, 8'h00);
        end
        rst_n = 1'b1;
        drive(4'b1111, 4'b1111);
        checks++;
        if (bus8.grant !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_grant got %b want %b", bus8.grant, 4'b0001);
        end
        checks++;
        if ({bus1.grant, bus1.owner, bus1.busy, bus1.timeout} !== exp_vec(1)) begin
            errors++;
            $display("FAIL reset_first_grant_max1 got %b want %b",
                     {bus1.grant, bus1.owner, bus1.busy, bus1.timeout}, exp_vec(1));
        end
    endtask

    task automatic test_single_user;
        logic [3:0] want [4];
        want = '{4'b0100, 4'b0100, 4'b0100, 4'b0000};
        repeat (2) drive(4'b0000, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            drive((i < 3) ? 4'b0100 : 4'b0000, 4'b0000);
            checks++;
            if (bus8.grant !== want[i] || bus8.owner !== 2'd2 || bus8.timeout !== 1'b0) begin
                errors++;
                $display("FAIL single_user[%0d] got g=%b o=%0d t=%b want g=%b o=2 t=0",
                         i, bus8.grant, bus8.owner, bus8.timeout, want[i]);
            end
        end
    endtask

    task automatic test_saturation;
        int pulses;
        int run;
        int max_run;
        pulses  = 0;
        run     = 0;
        max_run = 0;
        for (int i = 0; i < 60; i++) begin
            drive(4'b1111, 4'b0000);
            checks++;
            if ({bus8.grant, bus8.owner, bus8.busy, bus8.timeout} !== exp_vec(0)) begin
                errors++;
                $display("FAIL saturation[%0d] got %b want %b", i,
                         {bus8.grant, bus8.owner, bus8.busy, bus8.timeout}, exp_vec(0));
            end
            if (bus8.timeout) pulses++;
            run = bus8.busy ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
        checks++;
        if (max_run != 8 || pulses < 5) begin
            errors++;
            $display("FAIL saturation_shape got run=%0d pulses=%0d want run=8 pulses>=5",
                     max_run, pulses);
        end
    endtask

    task automatic test_rotation;
        repeat (2) drive(4'b0000, 4'b0000);
        repeat (2) drive(4'b0010, 4'b0000);
        drive(4'b0101, 4'b0000);
        checks++;
        if (bus8.grant !== 4'b0000) begin
            errors++;
            $display("FAIL rotation_gap got %b want %b", bus8.grant, 4'b0000);
        end
        drive(4'b0101, 4'b0000);
        checks++;
        if (bus8.grant !== 4'b0100 || bus8.owner !== 2'd2) begin
            errors++;
            $display("FAIL rotation_pick got g=%b o=%0d want g=0100 o=2", bus8.grant, bus8.owner);
        end
    endtask

    task automatic test_boundary;
        repeat (2) drive(4'b0000, 4'b0000);
        repeat (8) drive(4'b1000, 4'b0000);
        checks++;
        if (bus8.grant !== 4'b1000) begin
            errors++;
            $display("FAIL boundary_held got %b want %b", bus8.grant, 4'b1000);
        end
        drive(4'b0000, 4'b0000);
        checks++;
        if (bus8.grant !== 4'b0000 || bus8.timeout !== 1'b0) begin
            errors++;
            $display("FAIL boundary_drop got g=%b t=%b want g=0000 t=0", bus8.grant, bus8.timeout);
        end
        repeat (2) drive(4'b0000, 4'b0000);
        repeat (9) drive(4'b1000, 4'b0000);
        checks++;
        if (bus8.grant !== 4'b0000 || bus8.timeout !== 1'b1) begin
            errors++;
            $display("FAIL boundary_expire got g=%b t=%b want g=0000 t=1", bus8.grant, bus8.timeout);
        end
        drive(4'b1000, 4'b0000);
        checks++;
        if (bus8.grant !== 4'b1000 || bus8.timeout !== 1'b0) begin
            errors++;
            $display("FAIL boundary_regrant got g=%b t=%b want g=1000 t=0", bus8.grant, bus8.timeout);
        end
    endtask

    task automatic test_max_hold_one;
        int busy_cycles;
        busy_cycles = 0;
        repeat (2) drive(4'b0000, 4'b0000);
        for (int i = 0; i < 12; i++) begin
            drive(4'b0000, 4'b0011);
            checks++;
            if ({bus1.grant, bus1.owner, bus1.busy, bus1.timeout} !== exp_vec(1)) begin
                errors++;
                $display("FAIL max1[%0d] got %b want %b", i,
                         {bus1.grant, bus1.owner, bus1.busy, bus1.timeout}, exp_vec(1));
            end
            if (bus1.busy) busy_cycles++;
        end
        checks++;
        if (busy_cycles != 6) begin
            errors++;
            $display("FAIL max1_duty got %0d want %0d", busy_cycles, 6);
        end
    endtask

    task automatic test_reset_mid_grant;
        repeat (2) drive(4'b0000, 4'b0000);
        drive(4'b1000, 4'b0000);
        checks++;
        if (bus8.grant !== 4'b1000) begin
            errors++;
            $display("FAIL midrst_pre got %b want %b", bus8.grant, 4'b1000);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus8.grant !== 4'b0000 || bus8.busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async got g=%b b=%b want g=0000 b=0", bus8.grant, bus8.busy);
        end
        bus8.req = 4'b1001;
        model_reset(0);
        model_reset(1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b1001, 4'b0000);
        checks++;
        if (bus8.grant !== 4'b0001 || bus8.owner !== 2'd0) begin
            errors++;
            $display("FAIL midrst_after got g=%b o=%0d want g=0001 o=0", bus8.grant, bus8.owner);
        end
    endtask

    task automatic test_random;
        logic [3:0] r8;
        logic [3:0] r1;
        int         hold;
        hold = 0;
        r8   = 4'b0000;
        r1   = 4'b0000;
        for (int i = 0; i < 500; i++) begin
            if (hold == 0) begin
                r8   = 4'($urandom_range(0, 15));
                r1   = 4'($urandom_range(0, 15));
                hold = $urandom_range(1, 12);
            end
            hold--;
            drive(r8, r1);
            checks++;
            if ({bus8.grant, bus8.owner, bus8.busy, bus8.timeout} !== exp_vec(0) ||
                bus8.busy !== (|bus8.grant)) begin
                errors++;
                $display("FAIL random8[%0d] got %b want %b", i,
                         {bus8.grant, bus8.owner, bus8.busy, bus8.timeout}, exp_vec(0));
            end
            checks++;
            if ({bus1.grant, bus1.owner, bus1.busy, bus1.timeout} !== exp_vec(1) ||
                bus1.busy !== (|bus1.grant)) begin
                errors++;
                $display("FAIL random1[%0d] got %b want %b", i,
                         {bus1.grant, bus1.owner, bus1.busy, bus1.timeout}, exp_vec(1));
            end
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        bus8.req = 4'b0000;
        bus1.req = 4'b0000;
        test_reset();
        test_single_user();
        test_saturation();
        test_rotation();
        test_boundary();
        test_max_hold_one();
        test_reset_mid_grant();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
